// File: rtl/uart_link_ctl.sv
// uart_link_ctl: frames local x/y/level into 5-byte checksummed UART packets and
// parses incoming packets into validated remote-player state with link supervision.
module uart_link_ctl #(
    parameter int BYTE_TIMEOUT = 100_000,
    parameter int LINK_TIMEOUT = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [1:0]  level,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] remote_x,
    output logic [11:0] remote_y,
    output logic [1:0]  remote_level,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        link_up,
    output logic        tx_busy
);
    localparam int BW = $clog2(BYTE_TIMEOUT + 1);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);

    typedef enum logic [2:0] {T_IDLE, T_HDR, T_B1, T_B2, T_B3, T_CHK} tx_state_t;
    typedef enum logic [2:0] {R_HDR, R_B1, R_B2, R_B3, R_CHK} rx_state_t;

    tx_state_t ts, ts_n;
    rx_state_t rs, rs_n;
    logic          pending, start, good, bad, timeout;
    logic [7:0]    b1, b2, b3, r1, r2, r3;
    logic [10:0]   rem_x, rem_y;
    logic [1:0]    rem_l;
    logic [BW-1:0] tmr;
    logic [LW-1:0] lcnt;
    logic          unused;

    assign unused       = ^{x_pos[11], y_pos[11]};
    assign start        = (ts == T_IDLE) && (frame_tick || pending);
    assign tx_valid     = ts != T_IDLE;
    assign tx_busy      = ts != T_IDLE;
    assign remote_x     = {1'b0, rem_x};
    assign remote_y     = {1'b0, rem_y};
    assign remote_level = rem_l;
    assign link_up      = lcnt != '0;
    assign timeout      = (rs != R_HDR) && (tmr == BW'(BYTE_TIMEOUT));

    always_comb begin
        ts_n    = ts;
        tx_data = 8'h00;
        case (ts)
            T_IDLE:  ts_n = start ? T_HDR : T_IDLE;
            T_HDR:   begin tx_data = 8'hA5;        ts_n = tx_ready ? T_B1   : T_HDR; end
            T_B1:    begin tx_data = b1;           ts_n = tx_ready ? T_B2   : T_B1;  end
            T_B2:    begin tx_data = b2;           ts_n = tx_ready ? T_B3   : T_B2;  end
            T_B3:    begin tx_data = b3;           ts_n = tx_ready ? T_CHK  : T_B3;  end
            T_CHK:   begin tx_data = b1 ^ b2 ^ b3; ts_n = tx_ready ? T_IDLE : T_CHK; end
            default: ts_n = T_IDLE;
        endcase
    end

    // snapshot happens only on packet start so a packet is always self-consistent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts      <= T_IDLE;
            pending <= 1'b0;
            b1      <= 8'h00;
            b2      <= 8'h00;
            b3      <= 8'h00;
        end else begin
            ts      <= ts_n;
            pending <= start ? 1'b0 : (pending || (frame_tick && ts != T_IDLE));
            if (start) begin
                b1 <= x_pos[7:0];
                b2 <= {y_pos[4:0], x_pos[10:8]};
                b3 <= {level, y_pos[10:5]};
            end
        end
    end

    always_comb begin
        rs_n = rs;
        good = 1'b0;
        bad  = 1'b0;
        if (timeout) begin
            rs_n = R_HDR;
            bad  = 1'b1;
        end else if (rx_valid) begin
            case (rs)
                R_HDR:   rs_n = (rx_data == 8'hA5) ? R_B1 : R_HDR;
                R_B1:    rs_n = R_B2;
                R_B2:    rs_n = R_B3;
                R_B3:    rs_n = R_CHK;
                R_CHK:   begin
                    rs_n = R_HDR;
                    good = rx_data == (r1 ^ r2 ^ r3);
                    bad  = !good;
                end
                default: rs_n = R_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs        <= R_HDR;
            r1        <= 8'h00;
            r2        <= 8'h00;
            r3        <= 8'h00;
            rem_x     <= '0;
            rem_y     <= '0;
            rem_l     <= '0;
            tmr       <= '0;
            lcnt      <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rs        <= rs_n;
            frame_ok  <= good;
            frame_err <= bad;
            tmr       <= (rx_valid || rs == R_HDR || timeout) ? '0 : tmr + 1'b1;
            lcnt      <= good ? LW'(LINK_TIMEOUT) : (lcnt != '0 ? lcnt - 1'b1 : '0);
            if (rx_valid && !timeout) begin
                if (rs == R_B1) r1 <= rx_data;
                if (rs == R_B2) r2 <= rx_data;
                if (rs == R_B3) r3 <= rx_data;
            end
            if (good) begin
                rem_x <= {r2[2:0], r1};
                rem_y <= {r3[5:0], r2[7:3]};
                rem_l <= r3[7:6];
            end
        end
    end
endmodule

// File: tb/tb_uart_link_ctl.sv
// tb_uart_link_ctl: directed scenarios for the UART link controller with
// hand-computed packet bytes and small timeouts.
module tb_uart_link_ctl;
    localparam int BT = 20;
    localparam int LT = 200;

    logic        clk = 0, rst = 1, frame_tick = 0, tx_ready = 1, rx_valid = 0;
    logic [11:0] x_pos = 0, y_pos = 0;
    logic [1:0]  level = 0;
    logic [7:0]  rx_data = 0, tx_data;
    logic        tx_valid, frame_ok, frame_err, link_up, tx_busy;
    logic [11:0] remote_x, remote_y;
    logic [1:0]  remote_level;
    int total = 0, bad = 0;

    uart_link_ctl #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .x_pos(x_pos), .y_pos(y_pos),
        .level(level), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .remote_x(remote_x), .remote_y(remote_y),
        .remote_level(remote_level), .frame_ok(frame_ok), .frame_err(frame_err),
        .link_up(link_up), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1;
        step();
        rx_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        total++;
        if ({tx_valid, tx_data, tx_busy, frame_ok, frame_err, link_up} !== 12'h0) begin
            bad++;
            $display("FAIL reset_ctrl got v=%b d=%h busy=%b ok=%b err=%b up=%b exp all 0",
                     tx_valid, tx_data, tx_busy, frame_ok, frame_err, link_up);
        end
        total++;
        if ({remote_x, remote_y, remote_level} !== 26'h0) begin
            bad++;
            $display("FAIL reset_remote got x=%h y=%h l=%h exp 0", remote_x, remote_y, remote_level);
        end
        rst = 0;
        step();
    endtask

    task automatic test_tx_basic();
        logic [7:0] exp [5] = '{8'hA5, 8'h23, 8'h29, 8'h82, 8'h88};
        x_pos = 12'h123; y_pos = 12'h045; level = 2;
        frame_tick = 1;
        step();
        frame_tick = 0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                bad++;
                $display("FAIL tx_byte%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp[i]);
            end
            step();
        end
        total++;
        if (tx_busy !== 1'b0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL tx_done got busy=%b v=%b exp 0 0", tx_busy, tx_valid);
        end
    endtask

    task automatic test_tx_stall();
        logic [7:0] exp1 [5] = '{8'hA5, 8'h23, 8'h29, 8'h82, 8'h88};
        logic [7:0] exp2 [5] = '{8'hA5, 8'h56, 8'h4C, 8'h7C, 8'h66};
        int extra = 0;
        x_pos = 12'h123; y_pos = 12'h045; level = 2;
        frame_tick = 1;
        step();
        frame_tick = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                tx_ready = 0;
                x_pos = 12'hC56; y_pos = 12'h789; level = 1;
                for (int c = 0; c < 10; c++) begin
                    total++;
                    if (tx_valid !== 1'b1 || tx_data !== 8'h29) begin
                        bad++;
                        $display("FAIL stall_hold%0d got v=%b d=%h exp v=1 d=29", c, tx_valid, tx_data);
                    end
                    frame_tick = (c == 2 || c == 5);
                    step();
                    frame_tick = 0;
                end
                tx_ready = 1;
            end
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp1[i]) begin
                bad++;
                $display("FAIL stall_byte%0d got v=%b d=%h exp d=%h", i, tx_valid, tx_data, exp1[i]);
            end
            step();
        end
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_gap got v=%b exp 0", tx_valid);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp2[i]) begin
                bad++;
                $display("FAIL pend_byte%0d got v=%b d=%h exp d=%h", i, tx_valid, tx_data, exp2[i]);
            end
            step();
        end
        for (int c = 0; c < 8; c++) begin
            if (tx_valid !== 1'b0) extra++;
            step();
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL pend_merge got %0d extra busy cycles exp 0", extra);
        end
    endtask

    task automatic test_rx_good();
        send_byte(8'h00); send_byte(8'hA5); send_byte(8'h23);
        send_byte(8'h29); send_byte(8'h82); send_byte(8'h88);
        total++;
        if (frame_ok !== 1'b1 || frame_err !== 1'b0 || link_up !== 1'b1) begin
            bad++;
            $display("FAIL rx_good_flags got ok=%b err=%b up=%b exp 1 0 1", frame_ok, frame_err, link_up);
        end
        total++;
        if (remote_x !== 12'h123 || remote_y !== 12'h045 || remote_level !== 2'd2) begin
            bad++;
            $display("FAIL rx_good_data got x=%h y=%h l=%0d exp 123 045 2", remote_x, remote_y, remote_level);
        end
        step();
        total++;
        if (frame_ok !== 1'b0) begin
            bad++;
            $display("FAIL rx_ok_pulse got ok=%b exp 0", frame_ok);
        end
    endtask

    task automatic test_rx_bad();
        int oks = 0;
        send_byte(8'hA5); send_byte(8'h23); send_byte(8'h29); send_byte(8'h82); send_byte(8'h89);
        total++;
        if (frame_err !== 1'b1 || frame_ok !== 1'b0) begin
            bad++;
            $display("FAIL rx_bad_flags got ok=%b err=%b exp 0 1", frame_ok, frame_err);
        end
        total++;
        if (remote_x !== 12'h123 || remote_y !== 12'h045 || remote_level !== 2'd2) begin
            bad++;
            $display("FAIL rx_bad_hold got x=%h y=%h l=%0d exp 123 045 2", remote_x, remote_y, remote_level);
        end
        send_byte(8'hA5); send_byte(8'h23); send_byte(8'h29); send_byte(8'h82); send_byte(8'hA5);
        total++;
        if (frame_err !== 1'b1) begin
            bad++;
            $display("FAIL rx_a5_chk got err=%b exp 1", frame_err);
        end
        send_byte(8'h56); send_byte(8'h4C); send_byte(8'h7C); send_byte(8'h66);
        if (frame_ok) oks++;
        step();
        total++;
        if (oks != 0 || remote_x !== 12'h123) begin
            bad++;
            $display("FAIL rx_a5_nohdr got oks=%0d x=%h exp 0 123", oks, remote_x);
        end
        send_byte(8'hA5); send_byte(8'h56); send_byte(8'h4C); send_byte(8'h7C); send_byte(8'h66);
        total++;
        if (frame_ok !== 1'b1 || remote_x !== 12'h456 || remote_y !== 12'h789 || remote_level !== 2'd1) begin
            bad++;
            $display("FAIL rx_recover got ok=%b x=%h y=%h l=%0d exp 1 456 789 1",
                     frame_ok, remote_x, remote_y, remote_level);
        end
    endtask

    task automatic test_timeouts();
        int n = 0;
        int oks = 0;
        send_byte(8'hA5); send_byte(8'h23);
        while (frame_err !== 1'b1 && n < 4 * BT) begin
            step();
            n++;
        end
        total++;
        if (frame_err !== 1'b1 || n < BT - 1 || n > BT + 2) begin
            bad++;
            $display("FAIL byte_timeout got err=%b after %0d cycles exp 1 near %0d", frame_err, n, BT);
        end
        send_byte(8'h29); send_byte(8'h82); send_byte(8'h88);
        if (frame_ok) oks++;
        step();
        if (frame_ok) oks++;
        total++;
        if (oks != 0) begin
            bad++;
            $display("FAIL resync_hdr got oks=%0d exp 0", oks);
        end
        send_byte(8'hA5); send_byte(8'h23); send_byte(8'h29); send_byte(8'h82); send_byte(8'h88);
        total++;
        if (link_up !== 1'b1 || remote_x !== 12'h123) begin
            bad++;
            $display("FAIL link_reload got up=%b x=%h exp 1 123", link_up, remote_x);
        end
        n = 0;
        while (link_up === 1'b1 && n < 3 * LT) begin
            step();
            n++;
        end
        total++;
        if (link_up !== 1'b0 || n < LT - 1 || n > LT + 1) begin
            bad++;
            $display("FAIL link_timeout got up=%b after %0d cycles exp 0 near %0d", link_up, n, LT);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [5] = '{8'hA5, 8'h23, 8'h29, 8'h82, 8'h88};
        int oks = 0;
        x_pos = 12'h123; y_pos = 12'h045; level = 2;
        frame_tick = 1;
        rx_data = 8'hA5; rx_valid = 1;
        step();
        frame_tick = 0;
        rx_data = 8'h23;
        step();
        rx_data = 8'h29;
        step();
        rx_valid = 0;
        total++;
        if (tx_data !== 8'h29) begin
            bad++;
            $display("FAIL mid_setup got d=%h exp 29", tx_data);
        end
        rst = 1;
        #1;
        total++;
        if ({tx_valid, tx_data, tx_busy, frame_ok, frame_err, link_up} !== 12'h0 ||
            {remote_x, remote_y, remote_level} !== 26'h0) begin
            bad++;
            $display("FAIL mid_reset got v=%b d=%h busy=%b up=%b x=%h y=%h l=%0d exp all 0",
                     tx_valid, tx_data, tx_busy, link_up, remote_x, remote_y, remote_level);
        end
        step();
        rst = 0;
        step();
        send_byte(8'h82); send_byte(8'h88);
        if (frame_ok) oks++;
        step();
        total++;
        if (oks != 0 || remote_x !== 12'h000) begin
            bad++;
            $display("FAIL mid_rx_abort got oks=%0d x=%h exp 0 000", oks, remote_x);
        end
        frame_tick = 1;
        step();
        frame_tick = 0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                bad++;
                $display("FAIL mid_tx_byte%0d got v=%b d=%h exp d=%h", i, tx_valid, tx_data, exp[i]);
            end
            step();
        end
        total++;
        if (tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_tx_done got busy=%b exp 0", tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        step();
        test_tx_stall();
        test_rx_good();
        test_rx_bad();
        test_timeouts();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
